chn_len_regs: RTL and testbench

CHN_LEN_REGS -- requirements
Module: chn_len_regs

---
 rtl/chn_len_regs.sv | 129 ++++++++++++
 tb/tb_chn_len_regs.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chn_len_regs.sv
// rtl/chn_len_regs.sv - per-channel length counter, config and trigger registers
module chn_len_regs #(
    parameter int NCH = 4,
    parameter int LEN_W = 6,
    localparam int AW = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              apu_reset,
    input  logic              apu_wr,
    input  logic              ncpu_rd,
    input  logic [AW-1:0]     addr,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    output logic              d_oe,
    input  logic              tick_256hz,
    output logic [NCH-1:0]    ch_restart,
    output logic [NCH-1:0]    ch_active,
    output logic [NCH*16-1:0] cfg_q
);
    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    logic [LEN_W-1:0] cnt [NCH];
    logic [LEN_W-1:0] cnt_nx [NCH];
    logic [7:0]       cfg_r [NCH];
    logic [7:0]       cfg_nx [NCH];
    logic [7:0]       poly_r [NCH];
    logic [7:0]       poly_nx [NCH];
    logic [NCH-1:0]   expired, exp_nx;
    logic [NCH-1:0]   len_en, en_nx;
    logic [NCH-1:0]   active, act_nx;
    logic [NCH-1:0]   restart, rst_nx;
    logic [NCH-1:0]   wr_ch;
    logic [AW-1:0]    ch_field;
    int               sel;
    logic             ch_valid;

    assign ch_field = addr >> 2;
    assign sel      = int'(ch_field);
    assign ch_valid = (sel < NCH);

    always_comb begin
        wr_ch = '0;
        for (int c = 0; c < NCH; c++) begin
            wr_ch[c] = apu_wr && ch_valid && (sel == c);
        end
    end

    // Register write (trigger first) is resolved before the tick so the tick sees the new len_en.
    always_comb begin
        cnt_nx  = cnt;
        cfg_nx  = cfg_r;
        poly_nx = poly_r;
        exp_nx  = expired;
        en_nx   = len_en;
        act_nx  = active;
        rst_nx  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (wr_ch[c]) begin
                case (addr[1:0])
                    2'd0: cnt_nx[c] = d_in[LEN_W-1:0];
                    2'd1: cfg_nx[c] = d_in;
                    2'd2: poly_nx[c] = d_in;
                    default: begin
                        en_nx[c] = d_in[6];
                        if (d_in[7]) begin
                            act_nx[c] = 1'b1;
                            exp_nx[c] = 1'b0;
                            rst_nx[c] = 1'b1;
                        end
                    end
                endcase
            end
            if (tick_256hz && !(wr_ch[c] && addr[1:0] == 2'd0) && en_nx[c] && !exp_nx[c]) begin
                cnt_nx[c] = cnt[c] + 1'b1;
                if (cnt[c] == CNT_MAX && !rst_nx[c]) begin
                    exp_nx[c] = 1'b1;
                    act_nx[c] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge apu_reset) begin
        if (apu_reset) begin
            for (int c = 0; c < NCH; c++) begin
                cnt[c]    <= '0;
                cfg_r[c]  <= '0;
                poly_r[c] <= '0;
            end
            expired <= '0;
            len_en  <= '0;
            active  <= '0;
            restart <= '0;
        end else begin
            cnt     <= cnt_nx;
            cfg_r   <= cfg_nx;
            poly_r  <= poly_nx;
            expired <= exp_nx;
            len_en  <= en_nx;
            active  <= act_nx;
            restart <= rst_nx;
        end
    end

    always_comb begin
        d_out = 8'hFF;
        for (int c = 0; c < NCH; c++) begin
            if (ch_valid && sel == c) begin
                case (addr[1:0])
                    2'd1:    d_out = cfg_r[c];
                    2'd2:    d_out = poly_r[c];
                    2'd3:    d_out = {1'b1, len_en[c], 6'h3F};
                    default: d_out = 8'hFF;
                endcase
            end
        end
    end

    always_comb begin
        cfg_q = '0;
        for (int c = 0; c < NCH; c++) begin
            cfg_q[c*16 +: 16] = {poly_r[c], cfg_r[c]};
        end
    end

    assign d_oe       = !ncpu_rd && ch_valid;
    assign ch_restart = restart;
    assign ch_active  = active;
endmodule

// File: tb/tb_chn_len_regs.sv
// tb/tb_chn_len_regs.sv - randomized and directed bench for chn_len_regs against a reference model
module tb_chn_len_regs;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        apu_reset, apu_wr, ncpu_rd, tick;
    logic [3:0]  addr;
    logic [7:0]  d_in, d_out;
    logic        d_oe;
    logic [3:0]  ch_restart, ch_active;
    logic [63:0] cfg_q;

    logic        apu_wr2, ncpu_rd2, tick2;
    logic [3:0]  addr2;
    logic [7:0]  d_in2, d_out2;
    logic        d_oe2;
    logic [2:0]  ch_restart2, ch_active2;
    logic [47:0] cfg_q2;

    chn_len_regs #(.NCH(4), .LEN_W(6)) dut (
        .clk(clk), .apu_reset(apu_reset), .apu_wr(apu_wr), .ncpu_rd(ncpu_rd),
        .addr(addr), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .tick_256hz(tick),
        .ch_restart(ch_restart), .ch_active(ch_active), .cfg_q(cfg_q)
    );

    chn_len_regs #(.NCH(3), .LEN_W(8)) dut2 (
        .clk(clk), .apu_reset(apu_reset), .apu_wr(apu_wr2), .ncpu_rd(ncpu_rd2),
        .addr(addr2), .d_in(d_in2), .d_out(d_out2), .d_oe(d_oe2), .tick_256hz(tick2),
        .ch_restart(ch_restart2), .ch_active(ch_active2), .cfg_q(cfg_q2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: counters as plain integers modulo 64
    int m_cnt [4];
    int m_cfg [4];
    int m_poly [4];
    bit m_exp [4];
    bit m_en [4];
    bit m_act [4];
    bit m_rst [4];

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0; m_cfg[c] = 0; m_poly[c] = 0;
            m_exp[c] = 0; m_en[c] = 0; m_act[c] = 0; m_rst[c] = 0;
        end
    endfunction

    function automatic void model_clock(bit wr, int a, int d, bit tk);
        int ch = a / 4;
        int idx = a % 4;
        for (int c = 0; c < 4; c++) begin
            bit trig = 0;
            bit lw = 0;
            if (wr && ch == c) begin
                case (idx)
                    0: lw = 1;
                    1: m_cfg[c] = d;
                    2: m_poly[c] = d;
                    default: begin
                        m_en[c] = ((d / 64) % 2) == 1;
                        if (d >= 128) begin
                            trig = 1; m_act[c] = 1; m_exp[c] = 0;
                        end
                    end
                endcase
            end
            if (lw) m_cnt[c] = d % 64;
            else if (tk && m_en[c] && !m_exp[c]) begin
                m_cnt[c] = (m_cnt[c] + 1) % 64;
                if (m_cnt[c] == 0 && !trig) begin
                    m_exp[c] = 1; m_act[c] = 0;
                end
            end
            m_rst[c] = trig;
        end
    endfunction

    function automatic int exp_read(int a);
        int ch = a / 4;
        case (a % 4)
            1: return m_cfg[ch];
            2: return m_poly[ch];
            3: return 128 + (m_en[ch] ? 64 : 0) + 63;
            default: return 255;
        endcase
    endfunction

    task automatic check_outputs(input string where);
        logic [3:0]  ea, er;
        logic [63:0] ec;
        for (int c = 0; c < 4; c++) begin
            ea[c] = m_act[c];
            er[c] = m_rst[c];
            ec[c*16 +: 16] = {8'(m_poly[c]), 8'(m_cfg[c])};
        end
        check_val({where, ".active"}, 64'(ch_active), 64'(ea));
        check_val({where, ".restart"}, 64'(ch_restart), 64'(er));
        check_val({where, ".cfg_q"}, cfg_q, ec);
    endtask

    task automatic do_cycle(input bit wr, input int a, input int d, input bit tk);
        apu_wr = wr; addr = 4'(a); d_in = 8'(d); tick = tk;
        @(posedge clk);
        model_clock(wr, a, d, tk);
        #1;
        apu_wr = 1'b0; tick = 1'b0;
        check_outputs("cyc");
    endtask

    task automatic read_chk(input int a, input string tag);
        ncpu_rd = 1'b0; addr = 4'(a);
        #1;
        check_val(tag, 64'(d_out), 64'(exp_read(a)));
        check_val({tag, ".oe"}, 64'(d_oe), 64'd1);
        ncpu_rd = 1'b1;
    endtask

    task automatic count_ticks(input int ch, output int n);
        n = 0;
        while (n < 400) begin
            do_cycle(0, 0, 0, 1);
            n++;
            if (!ch_active[ch]) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        apu_reset = 1'b1; apu_wr = 1'b0; ncpu_rd = 1'b1; tick = 1'b0; addr = '0; d_in = '0;
        apu_wr2 = 1'b0; ncpu_rd2 = 1'b1; tick2 = 1'b0; addr2 = '0; d_in2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check_val("reset.oe", 64'(d_oe), 64'd0);
        @(negedge clk) apu_reset = 1'b0;

        // LENGTH=62, trigger, two ticks to expiry
        do_cycle(1, 0, 62, 0);
        do_cycle(1, 3, 8'hC0, 0);
        check_val("trig.active", 64'(ch_active[0]), 64'd1);
        check_val("trig.restart", 64'(ch_restart[0]), 64'd1);
        do_cycle(0, 0, 0, 0);
        check_val("restart.once", 64'(ch_restart[0]), 64'd0);
        do_cycle(0, 0, 0, 1);
        check_val("tick1.active", 64'(ch_active[0]), 64'd1);
        do_cycle(0, 0, 0, 1);
        check_val("tick2.active", 64'(ch_active[0]), 64'd0);

        do_cycle(1, 3, 8'hC0, 0);
        check_val("retrig.active", 64'(ch_active[0]), 64'd1);
        count_ticks(0, n);
        check_val("reexpire.ticks", 64'(n), 64'd64);

        do_cycle(1, 3, 8'hC0, 0);
        do_cycle(1, 0, 10, 1);
        count_ticks(0, n);
        check_val("lenwr_tick.ticks", 64'(n), 64'd54);

        do_cycle(1, 3, 8'h80, 0);
        repeat (300) do_cycle(0, 0, 0, 1);
        check_val("len_dis.active", 64'(ch_active[0]), 64'd1);
        read_chk(3, "ctrl.read");
        check_val("ctrl.value", 64'(d_out), 64'hBF);
        read_chk(0, "length.read");

        // trigger and wrap on the same edge
        do_cycle(1, 8, 63, 0);
        do_cycle(1, 11, 8'h40, 0);
        do_cycle(1, 11, 8'hC0, 1);
        check_val("trig_wrap.active", 64'(ch_active[2]), 64'd1);
        do_cycle(0, 0, 0, 1);
        check_val("trig_wrap.after", 64'(ch_active[2]), 64'd1);

        // two channels expire on one tick
        do_cycle(1, 4, 63, 0);
        do_cycle(1, 12, 63, 0);
        do_cycle(1, 7, 8'hC0, 0);
        do_cycle(1, 15, 8'hC0, 0);
        do_cycle(0, 0, 0, 1);
        check_val("multi_expire", 64'({ch_active[3], ch_active[1]}), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            int a = int'($urandom % 16);
            int d = int'($urandom % 256);
            bit wr = ($urandom % 3) == 0;
            bit tk = ($urandom % 4) == 0;
            if ((a % 4) == 0 && ($urandom % 2) == 1) d = 56 + int'($urandom % 8);
            do_cycle(wr, a, d, tk);
            if (i % 5 == 0) read_chk(int'($urandom % 16), "rand.read");
        end

        // asynchronous reset while counting and with a restart pulse pending
        do_cycle(1, 5, 8'h33, 0);
        do_cycle(1, 4, 5, 0);
        do_cycle(1, 7, 8'hC0, 0);
        #2 apu_reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        check_val("async_reset.active", 64'(ch_active), 64'd0);
        check_val("async_reset.restart", 64'(ch_restart), 64'd0);
        read_chk(5, "async_reset.cfg_read");
        check_val("async_reset.cfg_value", 64'(d_out), 64'h00);
        apu_wr = 1'b1; addr = 4'd5; d_in = 8'h77; tick = 1'b1;
        @(posedge clk); #1;
        apu_wr = 1'b0; tick = 1'b0;
        check_val("reset_held.cfg_q", cfg_q, 64'd0);
        @(negedge clk) apu_reset = 1'b0;
        do_cycle(0, 0, 0, 0);

        // NCH=3, LEN_W=8 instance
        apu_wr2 = 1'b1; addr2 = 4'd5; d_in2 = 8'h5A;
        @(posedge clk); #1;
        apu_wr2 = 1'b0; ncpu_rd2 = 1'b0; addr2 = 4'd5;
        #1;
        check_val("n3.cfg_read", 64'(d_out2), 64'h5A);
        check_val("n3.cfg_oe", 64'(d_oe2), 64'd1);
        check_val("n3.cfg_q", 64'(cfg_q2[23:16]), 64'h5A);
        addr2 = 4'd13;
        #1;
        check_val("n3.ch3_oe", 64'(d_oe2), 64'd0);
        check_val("n3.ch3_dout", 64'(d_out2), 64'hFF);
        ncpu_rd2 = 1'b1;
        apu_wr2 = 1'b1; addr2 = 4'd0; d_in2 = 8'd250;
        @(posedge clk); #1;
        addr2 = 4'd3; d_in2 = 8'hC0;
        @(posedge clk); #1;
        apu_wr2 = 1'b0;
        check_val("n3.active", 64'(ch_active2[0]), 64'd1);
        n = 0;
        while (n < 400) begin
            tick2 = 1'b1;
            @(posedge clk); #1;
            tick2 = 1'b0;
            n++;
            if (!ch_active2[0]) break;
        end
        check_val("n3.len8_ticks", 64'(n), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
